// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB-Lite slave front-end for a single-port, byte-writable
// synchronous SRAM with one-cycle registered read data. A read that arrives
// while a write is in its data phase waits one cycle. Illegal transfers get a
// two-cycle ERROR response and never reach the SRAM.
module ahb_sram_ctrl #(
    parameter int WORDS = 8192,
    parameter int AW    = 22
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic          mem_ena,
    output logic [3:0]    mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,   // no data phase pending
        S_WR,     // write data phase, SRAM written this cycle
        S_RD,     // read data phase, mem_rdata valid
        S_RDS,    // read pushed back one cycle by a write
        S_ERR1,   // first ERROR cycle (stalled)
        S_ERR2    // second ERROR cycle (ready)
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] wr_addr_q;
    logic [3:0]    wr_lanes_q;
    logic [AW-1:0] rd_addr_q;

    logic          accept;
    logic          illegal;
    logic          wr_ok;
    logic          rd_ok;
    logic [3:0]    lanes;
    logic [AW-1:0] haddr_word;

    // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats alike.
    logic          unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    // NOTE: accept is gated by HRESETn so the combinational SRAM strobes stay
    // low while reset is held, whatever the bus is doing. RDS and ERR1 drive
    // HREADYOUT low, so no address phase can complete in them.
    assign accept = HRESETn & HSEL & HTRANS[1] & HREADY
                  & (state_q != S_RDS) & (state_q != S_ERR1);

    assign illegal = (HSIZE > 3'd2)
                   | ((HSIZE == 3'd1) & HADDR[0])
                   | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                   | ({2'b00, HADDR[31:2]} >= 32'(WORDS));

    assign wr_ok      = accept & ~illegal & HWRITE;
    assign rd_ok      = accept & ~illegal & ~HWRITE;
    assign haddr_word = HADDR[AW+1:2];

    // Byte-lane decode of the current address phase; data stays on its AHB lane.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        lanes = 4'b1111;
        case (HSIZE)
            3'd0:    lanes = 4'b0001 << HADDR[1:0];
            3'd1:    lanes = HADDR[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    // Next-state decision for the data phase that follows this cycle.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_RDS:   state_d = S_RD;
            S_ERR1:  state_d = S_ERR2;
            default: begin
                if (accept) begin
                    if (illegal)
                        state_d = S_ERR1;
                    else if (HWRITE)
                        state_d = S_WR;
                    else if (state_q == S_WR)
                        state_d = S_RDS;
                    else
                        state_d = S_RD;
                end
            end
        endcase
    end

    // FSM state, registered handshake outputs and latched transfer attributes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            HREADYOUT  <= 1'b1;
            HRESP      <= 1'b0;
            wr_addr_q  <= '0;
            wr_lanes_q <= '0;
            rd_addr_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment only, so every
            // register samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            HREADYOUT <= !((state_d == S_RDS) || (state_d == S_ERR1));
            HRESP     <= (state_d == S_ERR1) || (state_d == S_ERR2);
            if (wr_ok) begin
                wr_addr_q  <= haddr_word;
                wr_lanes_q <= lanes;
            end
            if (rd_ok) begin
                rd_addr_q <= haddr_word;
            end
        end
    end

    // SRAM strobes: pending write first, then deferred read, then a fresh read.
    always_comb begin
        mem_ena   = 1'b0;
        mem_wen   = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == S_WR) begin
            mem_ena   = 1'b1;
            mem_wen   = wr_lanes_q;
            mem_addr  = wr_addr_q;
            mem_wdata = HWDATA;
        end else if (state_q == S_RDS) begin
            mem_ena  = 1'b1;
            mem_addr = rd_addr_q;
        end else if (rd_ok) begin
            mem_ena  = 1'b1;
            mem_addr = haddr_word;
        end
    end

    assign HRDATA = (state_q == S_RD) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: directed and randomized AHB-Lite traffic against
// ahb_sram_ctrl with a behavioural SRAM and a byte-level reference memory.
module tb_ahb_sram_ctrl;

    localparam int WORDS = 8192;
    localparam int AW    = 22;

    logic          HCLK    = 1'b0;
    logic          HRESETn = 1'b0;
    logic          HSEL    = 1'b0;
    logic [31:0]   HADDR   = '0;
    logic [1:0]    HTRANS  = '0;
    logic          HWRITE  = 1'b0;
    logic [2:0]    HSIZE   = '0;
    logic [31:0]   HWDATA  = '0;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic          mem_ena;
    logic [3:0]    mem_wen;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    // Single slave on the bus: HREADY follows HREADYOUT unless overridden.
    logic hready_ovr = 1'b0;
    logic hready_val = 1'b1;
    assign HREADY = hready_ovr ? hready_val : HREADYOUT;

    ahb_sram_ctrl #(.WORDS(WORDS), .AW(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .mem_ena(mem_ena), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 HCLK = ~HCLK;

    // Behavioural SRAM macro: byte-writable, registered read output.
    logic [31:0] sram [0:WORDS-1];
    int          sram_idx;
    assign sram_idx = int'(mem_addr) % WORDS;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] wen);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (wen[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge HCLK) begin
        if (mem_ena) begin
            if (mem_wen != 4'b0000)
                sram[sram_idx] <= merge(sram[sram_idx], mem_wdata, mem_wen);
            else
                mem_rdata <= sram[sram_idx];
        end
    end

    // Reference model: byte-addressed memory updated in bus program order.
    logic [7:0] ref_mem [0:4*WORDS-1];

    typedef struct {
        bit          act;
        bit          write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] exp_rdata;
        logic [3:0]  lanes;
        int          waits;
    } xfer_t;

    xfer_t pend;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_illegal(input logic [2:0] size, input logic [31:0] addr);
        return (size > 3'd2) || (size == 3'd1 && addr[0]) ||
               (size == 3'd2 && addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(WORDS));
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        int b;
        b = int'(addr & 32'hFFFF_FFFC);
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic ref_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        for (int i = 0; i < (1 << size); i++) begin
            int a;
            a = int'(addr) + i;
            ref_mem[a] = wdata[8*(a%4) +: 8];
        end
    endtask

    // One bus beat, entered just after a rising edge: present the address
    // phase of a new transfer and complete the data phase of the pending one.
    task automatic step(input bit act, input bit write, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        xfer_t t;
        int    waits;
        bit    done;
        t.act       = act;
        t.write     = write;
        t.size      = size;
        t.addr      = addr;
        t.wdata     = wdata;
        t.err       = act && is_illegal(size, addr);
        t.exp_rdata = '0;
        t.lanes     = '0;
        t.waits     = 0;
        if (act) begin
            if (t.err)
                t.waits = 1;
            else if (!write && pend.act && pend.write && !pend.err)
                t.waits = 1;
            if (!t.err && write) begin
                ref_write(addr, size, wdata);
                t.lanes = 4'(((1 << (1 << size)) - 1) << int'(addr[1:0]));
            end
            if (!t.err && !write)
                t.exp_rdata = ref_word(addr);
        end

        if (act) begin
            HSEL   = 1'b1;
            HTRANS = {1'b1, 1'($urandom)};
        end else begin
            HSEL   = 1'($urandom);
            HTRANS = {1'b0, 1'($urandom)};
        end
        HADDR  = addr;
        HWRITE = write;
        HSIZE  = size;
        HWDATA = (pend.act && pend.write) ? pend.wdata : $urandom;

        waits = 0;
        done  = 1'b0;
        while (!done && waits < 4) begin
            @(negedge HCLK);
            if (HREADYOUT === 1'b1) begin
                done = 1'b1;
            end else begin
                if (pend.act && pend.err) begin
                    check({tag, "/err1_resp"}, 32'(HRESP), 32'd1);
                    check({tag, "/err1_ena"}, 32'(mem_ena), 32'd0);
                end else if (pend.act && !pend.write) begin
                    check({tag, "/rds_resp"}, 32'(HRESP), 32'd0);
                    check({tag, "/rds_ena"}, 32'(mem_ena), 32'd1);
                    check({tag, "/rds_wen"}, 32'(mem_wen), 32'd0);
                    check({tag, "/rds_addr"}, 32'(mem_addr), 32'(pend.addr[AW+1:2]));
                end
                waits++;
                @(posedge HCLK);
            end
        end
        if (!done)
            check({tag, "/stuck"}, 32'(HREADYOUT), 32'd1);

        check({tag, "/waits"}, 32'(waits), 32'(pend.waits));
        check({tag, "/hresp"}, 32'(HRESP), 32'(pend.act && pend.err));
        check({tag, "/hrdata"}, HRDATA,
              (pend.act && !pend.err && !pend.write) ? pend.exp_rdata : 32'h0);
        if (pend.act && !pend.err && pend.write) begin
            check({tag, "/wr_ena"}, 32'(mem_ena), 32'd1);
            check({tag, "/wr_wen"}, 32'(mem_wen), 32'(pend.lanes));
            check({tag, "/wr_addr"}, 32'(mem_addr), 32'(pend.addr[AW+1:2]));
            check({tag, "/wr_data"}, mem_wdata, pend.wdata);
        end else begin
            check({tag, "/ena"}, 32'(mem_ena), 32'(t.act && !t.err && !t.write));
            if (t.act && !t.err && !t.write)
                check({tag, "/rd_addr"}, 32'(mem_addr), 32'(t.addr[AW+1:2]));
        end

        @(posedge HCLK);
        #1;
        pend = t;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom, tag);
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "/hreadyout"}, 32'(HREADYOUT), 32'd1);
        check({tag, "/hresp"}, 32'(HRESP), 32'd0);
        check({tag, "/hrdata"}, HRDATA, 32'h0);
        check({tag, "/ena"}, 32'(mem_ena), 32'd0);
        check({tag, "/wen"}, 32'(mem_wen), 32'd0);
        check({tag, "/addr"}, 32'(mem_addr), 32'd0);
        check({tag, "/wdata"}, mem_wdata, 32'h0);
    endtask

    // Bound on total run time in case the design stops responding entirely.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    int          pool [12];
    logic [31:0] base;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] pre  [8];
    int unsigned r;

    initial begin
        pend = '{default: 0};

        // Reset held with random bus activity.
        hready_ovr = 1'b1;
        repeat (6) begin
            @(posedge HCLK);
            #1;
            HSEL = 1'($urandom); HTRANS = 2'($urandom); HADDR = $urandom & 32'h0000_7FFC;
            HWRITE = 1'($urandom); HSIZE = 3'($urandom_range(0, 2)); HWDATA = $urandom;
            hready_val = 1'($urandom);
            @(negedge HCLK);
            reset_outputs("reset");
        end
        HSEL = 1'b0; HTRANS = 2'b00; hready_ovr = 1'b0;
        #1 HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        // Write immediately followed by read of the same word.
        step(1'b1, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, "raw_wr");
        step(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "raw_rd");
        idle("raw_done");

        // Byte lanes then a halfword over the upper half.
        step(1'b1, 1'b1, 3'd0, 32'h20, {4{8'h11}}, "b0");
        step(1'b1, 1'b1, 3'd0, 32'h21, {4{8'h22}}, "b1");
        step(1'b1, 1'b1, 3'd0, 32'h22, {4{8'h33}}, "b2");
        step(1'b1, 1'b1, 3'd0, 32'h23, {4{8'h44}}, "b3");
        step(1'b1, 1'b1, 3'd1, 32'h22, {2{16'hAAAA}}, "h2");
        step(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, "rd20");
        idle("lanes_done");

        // Preload eight words, then read them back to back.
        for (int i = 0; i < 8; i++) begin
            pre[i] = $urandom;
            step(1'b1, 1'b1, 3'd2, 32'h100 + 32'(4*i), pre[i], "preload");
        end
        idle("preload_done");
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 3'd2, 32'h100 + 32'(4*i), 32'h0, "b2b_rd");
        idle("b2b_done");

        // Topmost legal word.
        step(1'b1, 1'b1, 3'd2, 32'(4*(WORDS-1)), 32'hC0FF_EE01, "top_wr");
        step(1'b1, 1'b0, 3'd2, 32'(4*(WORDS-1)), 32'h0, "top_rd");
        idle("top_done");

        // Illegal transfers, each followed directly by a legal read.
        step(1'b1, 1'b0, 3'd2, 32'h2, 32'h0, "err_word_mis");
        step(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "after_err_a");
        step(1'b1, 1'b1, 3'd1, 32'h1, 32'h1234_5678, "err_half_mis");
        step(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "after_err_b");
        step(1'b1, 1'b0, 3'd3, 32'h0, 32'h0, "err_size3");
        step(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "after_err_c");
        step(1'b1, 1'b1, 3'd2, 32'(4*WORDS), 32'hFFFF_FFFF, "err_range");
        step(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "after_err_d");
        idle("err_done");

        // Reset asserted during a read stall.
        step(1'b1, 1'b1, 3'd2, 32'h30, 32'h5A5A_0F0F, "rst_wr");
        step(1'b1, 1'b0, 3'd2, 32'h30, 32'h0, "rst_rd");
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
        check("rst_rds_stall", 32'(HREADYOUT), 32'd0);
        #1 HRESETn = 1'b0;
        #1 reset_outputs("rst_async");
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        reset_outputs("rst_held");
        #1 HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        pend = '{default: 0};
        step(1'b1, 1'b0, 3'd2, 32'h30, 32'h0, "post_rst_rd");
        idle("post_rst_done");

        // Randomized traffic over a pool of initialised words.
        pool[0] = 0;
        pool[1] = WORDS - 1;
        for (int i = 2; i < 12; i++)
            pool[i] = int'($urandom_range(2, WORDS - 2));
        for (int i = 0; i < 12; i++)
            step(1'b1, 1'b1, 3'd2, 32'(pool[i]) << 2, $urandom, "pool_init");
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                idle("rnd_idle");
            end else begin
                base = 32'(pool[$urandom_range(0, 11)]) << 2;
                sz   = 3'($urandom_range(0, 2));
                case (sz)
                    3'd0:    a = base + 32'($urandom_range(0, 3));
                    3'd1:    a = base + 32'(2 * $urandom_range(0, 1));
                    default: a = base;
                endcase
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 2))
                        0: sz = 3'($urandom_range(3, 7));
                        1: begin
                            sz = 3'($urandom_range(1, 2));
                            a  = base + 32'(1 + 2 * $urandom_range(0, 1));
                        end
                        default: a = 32'(4*WORDS) + ($urandom & 32'h7FFF_FFFC);
                    endcase
                end
                step(1'b1, 1'($urandom), sz, a, $urandom, "rnd");
            end
        end
        idle("flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
